// File: rtl/vga_mono_output_stage.sv
// Registered VGA output stage: 6-bit RGB to luma over a 3-clock pipeline, optional mono tint,
// sync lines delayed to match, and tint mode changes that take effect only at a vsync leading edge.
//
// state | meaning
// IDLE  | pending mode equals active mode
// ARMED | pending mode differs; it is committed at the next vsync leading edge
module vga_mono_output_stage #(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int PIPE_LAT         = 3
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] mode_req,
  input  logic       mode_wr,
  input  logic       mode_cycle,
  output logic [5:0] vga_r,
  output logic [5:0] vga_g,
  output logic [5:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [1:0] mode_active,
  output logic       mode_pend
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam logic SYNC_IDLE = VSYNC_ACTIVE_LOW;

  state_t state_q, state_d;
  logic [1:0] active_q, active_d;
  logic [1:0] pend_q, pend_d;
  logic       vs_prev_q, vs_prev_d;

  logic [11:0] p_r_q, p_r_d;
  logic [13:0] p_g_q, p_g_d;
  logic [10:0] p_b_q, p_b_d;
  logic [5:0]  r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic [5:0]  y2_q, y2_d;
  logic [5:0]  r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
  logic [5:0]  vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic [PIPE_LAT-1:0] hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;

  logic        vs_edge;
  logic [13:0] sum;

  always_comb begin
    vs_edge  = (vsync_in != SYNC_IDLE) && (vs_prev_q == SYNC_IDLE);
    pend_d   = pend_q;
    active_d = active_q;
    if (mode_wr) begin
      pend_d = mode_req;
    end else if (mode_cycle) begin
      pend_d = active_q + 2'd1;
    end
    // The edge commits what was pending before this clock; a same-clock strobe waits a frame.
    if (vs_edge) begin
      active_d = pend_q;
    end
    vs_prev_d = vsync_in;
    state_d   = (pend_d != active_d) ? ARMED : IDLE;
  end

  always_comb begin
    p_r_d = 12'(r_in) * 12'd54;
    p_g_d = 14'(g_in) * 14'd183;
    p_b_d = 11'(b_in) * 11'd18;
    r1_d  = r_in;
    g1_d  = g_in;
    b1_d  = b_in;

    sum   = 14'(p_r_q) + p_g_q + 14'(p_b_q);
    y2_d  = sum[13:8];
    r2_d  = r1_q;
    g2_d  = g1_q;
    b2_d  = b1_q;

    vga_r_d = r2_q;
    vga_g_d = g2_q;
    vga_b_d = b2_q;
    case (active_q)
      2'b01: begin
        vga_r_d = 6'd0;
        vga_g_d = y2_q;
        vga_b_d = 6'd0;
      end
      2'b10: begin
        vga_r_d = y2_q;
        vga_g_d = {1'b0, y2_q[5:1]};
        vga_b_d = 6'd0;
      end
      2'b11: begin
        vga_r_d = y2_q;
        vga_g_d = y2_q;
        vga_b_d = y2_q;
      end
      default: ;
    endcase

    hs_sr_d = {hs_sr_q[PIPE_LAT-2:0], hsync_in};
    vs_sr_d = {vs_sr_q[PIPE_LAT-2:0], vsync_in};
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state_q   <= IDLE;
      active_q  <= 2'b00;
      pend_q    <= 2'b00;
      vs_prev_q <= SYNC_IDLE;
      p_r_q     <= '0;
      p_g_q     <= '0;
      p_b_q     <= '0;
      r1_q      <= '0;
      g1_q      <= '0;
      b1_q      <= '0;
      y2_q      <= '0;
      r2_q      <= '0;
      g2_q      <= '0;
      b2_q      <= '0;
      vga_r_q   <= '0;
      vga_g_q   <= '0;
      vga_b_q   <= '0;
      hs_sr_q   <= {PIPE_LAT{SYNC_IDLE}};
      vs_sr_q   <= {PIPE_LAT{SYNC_IDLE}};
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      vs_prev_q <= vs_prev_d;
      p_r_q     <= p_r_d;
      p_g_q     <= p_g_d;
      p_b_q     <= p_b_d;
      r1_q      <= r1_d;
      g1_q      <= g1_d;
      b1_q      <= b1_d;
      y2_q      <= y2_d;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
      vga_r_q   <= vga_r_d;
      vga_g_q   <= vga_g_d;
      vga_b_q   <= vga_b_d;
      hs_sr_q   <= hs_sr_d;
      vs_sr_q   <= vs_sr_d;
    end
  end

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hsync   = hs_sr_q[PIPE_LAT-1];
  assign vga_vsync   = vs_sr_q[PIPE_LAT-1];
  assign mode_active = active_q;
  assign mode_pend   = (state_q == ARMED);

endmodule
